// File: rtl/alu_pipe_l7.sv
// RV32I register/immediate ALU execute unit with a configurable-depth
// valid/ready pipeline between decode and writeback; bubbles collapse.

package alu_pipe_l7_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned UOP_W = 4;
    localparam int unsigned REG_W = 5;
    localparam int unsigned SHA_W = 5;

    typedef enum logic [UOP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_LUI  = 4'd10
    } rv_uop_e;

endpackage

module alu_pipe_l7
    import alu_pipe_l7_pkg::*;
#(
    parameter int unsigned p_seq_num_bits = 5,
    parameter int unsigned p_num_stages   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      D_val,
    output logic                      D_rdy,
    input  logic [XLEN-1:0]           D_pc,
    input  logic [p_seq_num_bits-1:0] D_seq_num,
    input  logic [XLEN-1:0]           D_op1,
    input  logic [XLEN-1:0]           D_op2,
    input  logic [REG_W-1:0]          D_waddr,
    input  rv_uop_e                   D_uop,
    output logic                      W_val,
    input  logic                      W_rdy,
    output logic [XLEN-1:0]           W_pc,
    output logic [p_seq_num_bits-1:0] W_seq_num,
    output logic [REG_W-1:0]          W_waddr,
    output logic [XLEN-1:0]           W_wdata,
    output logic                      W_wen
);

    typedef struct packed {
        logic [XLEN-1:0]           pc;
        logic [p_seq_num_bits-1:0] seq_num;
        logic [REG_W-1:0]          waddr;
        logic [XLEN-1:0]           wdata;
        logic                      wen;
    } msg_t;

    logic [XLEN-1:0]         result_c;
    logic                    supported_c;
    logic [SHA_W-1:0]        shamt_c;
    msg_t                    in_msg_c;
    logic [p_num_stages-1:0] valid_c;
    logic [p_num_stages-1:0] load_c;
    msg_t                    stage_msg_c [p_num_stages];

    // Result is computed once at entry; later stages only carry it.
    always_comb begin
        result_c    = '0;
        supported_c = 1'b1;
        shamt_c     = D_op2[SHA_W-1:0];
        case (D_uop)
            OP_ADD:  result_c = D_op1 + D_op2;
            OP_SUB:  result_c = D_op1 - D_op2;
            OP_AND:  result_c = D_op1 & D_op2;
            OP_OR:   result_c = D_op1 | D_op2;
            OP_XOR:  result_c = D_op1 ^ D_op2;
            OP_SLT:  result_c = {{(XLEN-1){1'b0}}, ($signed(D_op1) < $signed(D_op2))};
            OP_SLTU: result_c = {{(XLEN-1){1'b0}}, (D_op1 < D_op2)};
            OP_SLL:  result_c = D_op1 << shamt_c;
            OP_SRL:  result_c = D_op1 >> shamt_c;
            OP_SRA:  result_c = $unsigned($signed(D_op1) >>> shamt_c);
            OP_LUI:  result_c = D_op2;
            default: supported_c = 1'b0;
        endcase
    end

    // Unsupported micro-ops still retire so the sequence number is not lost.
    always_comb begin
        in_msg_c.pc      = D_pc;
        in_msg_c.seq_num = D_seq_num;
        in_msg_c.waddr   = D_waddr;
        in_msg_c.wdata   = supported_c ? result_c : '0;
        in_msg_c.wen     = supported_c && (D_waddr != '0);
    end

    for (genvar k = 0; k < p_num_stages; k++) begin : g_stage
        logic valid_q;
        msg_t msg_q;
        logic up_val;
        msg_t up_msg;

        if (k == 0) begin : g_head
            assign up_val = D_val;
            assign up_msg = in_msg_c;
        end else begin : g_body
            assign up_val = valid_c[k-1];
            assign up_msg = stage_msg_c[k-1];
        end

        // Stage k may load when it or any stage downstream of it has room.
        assign load_c[k] = W_rdy | ~(&valid_c[p_num_stages-1:k]);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= 1'b0;
                msg_q   <= '0;
            end else if (load_c[k]) begin
                valid_q <= up_val;
                if (up_val) begin
                    msg_q <= up_msg;
                end
            end
        end

        assign valid_c[k]     = valid_q;
        assign stage_msg_c[k] = msg_q;
    end

    assign D_rdy     = load_c[0];
    assign W_val     = valid_c[p_num_stages-1];
    assign W_pc      = stage_msg_c[p_num_stages-1].pc;
    assign W_seq_num = stage_msg_c[p_num_stages-1].seq_num;
    assign W_waddr   = stage_msg_c[p_num_stages-1].waddr;
    assign W_wdata   = stage_msg_c[p_num_stages-1].wdata;
    assign W_wen     = stage_msg_c[p_num_stages-1].wen;

endmodule

// File: tb/tb_alu_pipe_l7.sv
// Self-checking bench for alu_pipe_l7: directed vectors, backpressure,
// bubble collapse, mid-flight reset and a randomized sweep against a queue model.

module tb_alu_pipe_l7;
    import alu_pipe_l7_pkg::*;

    localparam int unsigned SB = 6;
    localparam int unsigned N  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          D_val, D_rdy, W_val, W_rdy, W_wen;
    logic [31:0]   D_pc, D_op1, D_op2, W_pc, W_wdata;
    logic [SB-1:0] D_seq_num, W_seq_num;
    logic [4:0]    D_waddr, W_waddr;
    rv_uop_e       D_uop;

    alu_pipe_l7 #(.p_seq_num_bits(SB), .p_num_stages(N)) dut (
        .clk(clk), .rst(rst),
        .D_val(D_val), .D_rdy(D_rdy), .D_pc(D_pc), .D_seq_num(D_seq_num),
        .D_op1(D_op1), .D_op2(D_op2), .D_waddr(D_waddr), .D_uop(D_uop),
        .W_val(W_val), .W_rdy(W_rdy), .W_pc(W_pc), .W_seq_num(W_seq_num),
        .W_waddr(W_waddr), .W_wdata(W_wdata), .W_wen(W_wen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic [SB-1:0] seq;
        logic [4:0]    waddr;
        logic [31:0]   wdata;
        logic          wen;
    } exp_t;

    exp_t          expq[$];
    int            total = 0;
    int            bad   = 0;
    logic [31:0]   pc_ctr  = 32'h1000;
    logic [SB-1:0] seq_ctr = '0;
    logic          w_seen, d_acc;
    logic [31:0]   w_data_s;
    logic          w_wen_s;
    logic          hold_q = 1'b0;
    logic [31:0]   hold_pc, hold_wdata;
    logic [SB-1:0] hold_seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {supported, result} from the ISA definition using wide integer math.
    function automatic logic [32:0] ref_alu(input logic [3:0] uop, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        int     sh;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
        sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
        sh = int'(b % 32);
        case (uop)
            4'd0:    return {1'b1, 32'(ua + ub)};
            4'd1:    return {1'b1, 32'(ua - ub)};
            4'd2:    return {1'b1, a & b};
            4'd3:    return {1'b1, a | b};
            4'd4:    return {1'b1, a ^ b};
            4'd5:    return {1'b1, (sa < sb) ? 32'd1 : 32'd0};
            4'd6:    return {1'b1, (ua < ub) ? 32'd1 : 32'd0};
            4'd7:    return {1'b1, 32'(ua * (64'sd1 << sh))};
            4'd8:    return {1'b1, 32'(ua / (64'sd1 << sh))};
            4'd9:    return {1'b1, 32'(sa >>> sh)};
            4'd10:   return {1'b1, b};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic load_msg(input logic [3:0] uop, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] waddr);
        D_uop     = rv_uop_e'(uop);
        D_op1     = a;
        D_op2     = b;
        D_waddr   = waddr;
        D_pc      = pc_ctr;
        D_seq_num = seq_ctr;
        pc_ctr    = pc_ctr + 32'd4;
        seq_ctr   = seq_ctr + SB'(1);
        D_val     = 1'b1;
    endtask

    // One clock: inputs were driven at the negedge; sample, score, advance to next negedge.
    task automatic tick();
        exp_t        e;
        logic [32:0] r;
        #1;
        w_seen   = W_val;
        w_data_s = W_wdata;
        w_wen_s  = W_wen;
        d_acc    = 1'b0;
        if (hold_q) begin
            chk("hold_val", 32'(W_val), 32'd1);
            chk("hold_pc", W_pc, hold_pc);
            chk("hold_seq", 32'(W_seq_num), 32'(hold_seq));
            chk("hold_wdata", W_wdata, hold_wdata);
        end
        if (W_val && W_rdy) begin
            if (expq.size() == 0) begin
                chk("spurious_w", 32'(W_val), 32'd0);
            end else begin
                e = expq.pop_front();
                chk("w_pc", W_pc, e.pc);
                chk("w_seq", 32'(W_seq_num), 32'(e.seq));
                chk("w_waddr", 32'(W_waddr), 32'(e.waddr));
                chk("w_wdata", W_wdata, e.wdata);
                chk("w_wen", 32'(W_wen), 32'(e.wen));
            end
        end
        hold_q     = W_val && !W_rdy;
        hold_pc    = W_pc;
        hold_seq   = W_seq_num;
        hold_wdata = W_wdata;
        if (D_val && D_rdy) begin
            r       = ref_alu(4'(D_uop), D_op1, D_op2);
            e.pc    = D_pc;
            e.seq   = D_seq_num;
            e.waddr = D_waddr;
            e.wdata = r[32] ? r[31:0] : 32'h0;
            e.wen   = r[32] && (D_waddr != 5'd0);
            expq.push_back(e);
            d_acc = 1'b1;
        end
        @(negedge clk);
        if (d_acc) D_val = 1'b0;
    endtask

    // Send one message into an idle pipe and check latency plus spec-given result.
    task automatic direct(input string tag, input logic [3:0] uop, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] waddr,
                          input logic [31:0] exp_data, input logic exp_wen);
        int lat;
        W_rdy = 1'b1;
        load_msg(uop, a, b, waddr);
        tick();
        chk({tag, "_acc"}, 32'(d_acc), 32'd1);
        lat = 0;
        for (int i = 1; i <= int'(N) + 3; i++) begin
            tick();
            if (w_seen) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(N));
        chk({tag, "_wdata"}, w_data_s, exp_data);
        chk({tag, "_wen"}, 32'(w_wen_s), 32'(exp_wen));
    endtask

    initial begin
        int sent, run, gap;
        logic started;
        D_val = 1'b0; W_rdy = 1'b0; D_pc = '0; D_seq_num = '0;
        D_op1 = '0; D_op2 = '0; D_waddr = '0; D_uop = OP_ADD;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_wval", 32'(W_val), 32'd0);
        chk("rst_wdata", W_wdata, 32'h0);
        chk("rst_wpc", W_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_drdy", 32'(D_rdy), 32'd1);
        @(negedge clk);

        direct("add",   4'd0,  32'd5,        32'd7,        5'd3, 32'd12,        1'b1);
        direct("sub",   4'd1,  32'd0,        32'd1,        5'd4, 32'hFFFF_FFFF, 1'b1);
        direct("slt",   4'd5,  32'hFFFF_FFFF, 32'd1,       5'd5, 32'd1,         1'b1);
        direct("sltu",  4'd6,  32'hFFFF_FFFF, 32'd1,       5'd6, 32'd0,         1'b1);
        direct("sra",   4'd9,  32'h8000_0000, 32'h24,      5'd7, 32'hF800_0000, 1'b1);
        direct("sll",   4'd7,  32'd1,        32'h21,       5'd8, 32'd2,         1'b1);
        direct("lui",   4'd10, 32'h1234,     32'hABCD_E000, 5'd9, 32'hABCD_E000, 1'b1);
        direct("x0",    4'd0,  32'd5,        32'd7,        5'd0, 32'd12,        1'b0);
        direct("unsup", 4'd13, 32'd5,        32'd7,        5'd2, 32'd0,         1'b0);

        // Backpressure: sink stalled, N+1 messages offered, only N fit.
        W_rdy = 1'b0;
        sent  = 0;
        load_msg(4'd0, 32'd100, 32'd1, 5'd10);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (d_acc) begin
                sent++;
                if (sent < int'(N) + 1) load_msg(4'd0, 32'd100 + 32'(sent), 32'd1, 5'd10);
            end
        end
        chk("bp_accepted", 32'(sent), 32'(N));
        #1;
        chk("bp_drdy_full", 32'(D_rdy), 32'd0);
        @(negedge clk);
        W_rdy   = 1'b1;
        run     = 0;
        started = 1'b0;
        for (int c = 0; c < int'(N) + 6; c++) begin
            tick();
            if (d_acc) sent++;
            if (w_seen) begin
                started = 1'b1;
                run++;
            end else if (started) begin
                break;
            end
        end
        chk("bp_sent_all", 32'(sent), 32'(N + 1));
        chk("bp_burst", 32'(run), 32'(N + 1));
        chk("bp_queue_empty", 32'(expq.size()), 32'd0);

        // Bubble collapse: A held at the output, B must still climb behind it.
        W_rdy = 1'b0;
        load_msg(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd11);
        for (int c = 0; c < int'(N) + 3; c++) begin
            tick();
            if (w_seen) break;
        end
        chk("bub_a_at_out", 32'(w_seen), 32'd1);
        load_msg(4'd3, 32'h1, 32'h2, 5'd12);
        tick();
        chk("bub_b_acc", 32'(d_acc), 32'd1);
        for (int c = 0; c < int'(N) - 2; c++) tick();
        #1;
        chk("bub_drdy", 32'(D_rdy), 32'd1);
        @(negedge clk);
        W_rdy = 1'b1;
        tick();
        chk("bub_a_ret", 32'(w_seen), 32'd1);
        tick();
        chk("bub_b_next", 32'(w_seen), 32'd1);

        // Mid-flight reset discards everything in the pipe.
        W_rdy = 1'b0;
        sent  = 0;
        load_msg(4'd0, 32'd1, 32'd2, 5'd13);
        for (int c = 0; c < 8 && sent < 3; c++) begin
            tick();
            if (d_acc) begin
                sent++;
                if (sent < 3) load_msg(4'd0, 32'd1, 32'(sent), 5'd13);
            end
        end
        chk("mr_loaded", 32'(sent), 32'd3);
        rst = 1'b0;
        #1;
        chk("mr_wval", 32'(W_val), 32'd0);
        chk("mr_wdata", W_wdata, 32'h0);
        expq.delete();
        hold_q = 1'b0;
        D_val  = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        W_rdy = 1'b1;
        for (int c = 0; c < int'(N) + 3; c++) begin
            tick();
            chk("mr_no_stale", 32'(w_seen), 32'd0);
        end
        direct("post_rst", 4'd0, 32'd40, 32'd2, 5'd1, 32'd42, 1'b1);

        // Random sweep with random source gaps and sink stalls.
        gap = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!D_val) begin
                if (gap == 0) begin
                    load_msg(4'($urandom_range(0, 15)), rnd32(), rnd32(), 5'($urandom_range(0, 31)));
                    gap = $urandom_range(0, 3);
                end else begin
                    gap--;
                end
            end
            W_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        D_val = 1'b0;
        W_rdy = 1'b1;
        for (int c = 0; c < int'(N) + 10 && expq.size() != 0; c++) tick();
        chk("drain_empty", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
